// File: rtl/decode_rf_stage_if.sv
// Handshake and data bundle between fetch, the decode/RF stage, execute and writeback.
interface decode_rf_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              wb_en;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [4:0]        out_opcode;
  logic [AW-1:0]     out_rd;
  logic [DATA_W-1:0] out_rs_val;
  logic [DATA_W-1:0] out_rt_val;
  logic [DATA_W-1:0] out_imm;
  logic              out_wr_en;
  logic              out_illegal;

  modport master (
    output in_valid, in_instr, wb_en, wb_addr, wb_data, flush, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs_val, out_rt_val,
           out_imm, out_wr_en, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, wb_en, wb_addr, wb_data, flush, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs_val, out_rt_val,
           out_imm, out_wr_en, out_illegal
  );
endinterface

// File: rtl/decode_rf_stage.sv
// Decode and register-file stage: field decode, bypassed RF read, RAW scoreboard,
// one-cycle registered output with valid/ready and flush.
module decode_rf_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = $clog2(NREGS),
  parameter int unsigned ZERO_REG = 1
) (
  input logic               clock,
  input logic               reset,
  decode_rf_stage_if.slave  bus
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  pending, pending_nxt;

  logic [4:0]        d_op;
  logic [AW-1:0]     d_rd, d_rs, d_rt;
  logic [DATA_W-1:0] d_imm, d_rs_val, d_rt_val;
  logic              d_rd_rs, d_rd_rt, d_wr, d_ill;
  logic              rs_hit, rt_hit, hazard, accept, rf_we;

  logic              o_valid, o_wr, o_ill;
  logic [4:0]        o_op;
  logic [AW-1:0]     o_rd;
  logic [DATA_W-1:0] o_rs, o_rt, o_imm;

  logic unused_instr_bits;
  assign unused_instr_bits = ^bus.in_instr;

  // Field decode; anything not used by the format stays zero.
  always_comb begin
    d_op    = bus.in_instr[31:27];
    d_rd    = '0;
    d_rs    = '0;
    d_rt    = '0;
    d_imm   = '0;
    d_rd_rs = 1'b0;
    d_rd_rt = 1'b0;
    d_wr    = 1'b0;
    d_ill   = 1'b0;
    case (d_op)
      5'd2, 5'd3, 5'd4, 5'd5, 5'd9: begin
        d_rd    = bus.in_instr[18 +: AW];
        d_rs    = bus.in_instr[9 +: AW];
        d_rt    = bus.in_instr[0 +: AW];
        d_rd_rs = 1'b1;
        d_rd_rt = 1'b1;
        d_wr    = 1'b1;
      end
      5'd1: begin
        d_rd  = bus.in_instr[20 +: AW];
        d_imm = DATA_W'(bus.in_instr[19:0]);
        d_wr  = 1'b1;
      end
      5'd6: begin
        d_rd    = bus.in_instr[20 +: AW];
        d_rs    = bus.in_instr[0 +: AW];
        d_rd_rs = 1'b1;
        d_wr    = 1'b1;
      end
      5'd7: d_imm = DATA_W'(bus.in_instr[6:0]);
      5'd8: begin
        d_rs    = bus.in_instr[18 +: AW];
        d_rt    = bus.in_instr[9 +: AW];
        d_imm   = DATA_W'(bus.in_instr[8:0]);
        d_rd_rs = 1'b1;
        d_rd_rt = 1'b1;
      end
      5'd10: begin
        d_rs    = bus.in_instr[0 +: AW];
        d_rd_rs = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
  end

  // Operand read with same-cycle writeback bypass; a read of r0 is forced to zero.
  always_comb begin
    rs_hit   = bus.wb_en && (bus.wb_addr == d_rs);
    rt_hit   = bus.wb_en && (bus.wb_addr == d_rt);
    d_rs_val = '0;
    d_rt_val = '0;
    if (d_rd_rs && !((ZERO_REG != 0) && (d_rs == '0)))
      d_rs_val = rs_hit ? bus.wb_data : regs[d_rs];
    if (d_rd_rt && !((ZERO_REG != 0) && (d_rt == '0)))
      d_rt_val = rt_hit ? bus.wb_data : regs[d_rt];
    hazard = (d_rd_rs && pending[d_rs] && !rs_hit) ||
             (d_rd_rt && pending[d_rt] && !rt_hit);
  end

  assign bus.in_ready = !reset && !bus.flush && !hazard && (!o_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign rf_we        = bus.wb_en && !((ZERO_REG != 0) && (bus.wb_addr == '0));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard: flush and writeback clear, a new accept sets last so it wins.
  always_comb begin
    pending_nxt = pending;
    if (bus.flush && o_valid && o_wr) pending_nxt[o_rd] = 1'b0;
    if (bus.wb_en) pending_nxt[bus.wb_addr] = 1'b0;
    if (accept && d_wr && !((ZERO_REG != 0) && (d_rd == '0))) pending_nxt[d_rd] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_op    <= '0;
      o_rd    <= '0;
      o_rs    <= '0;
      o_rt    <= '0;
      o_imm   <= '0;
      o_wr    <= 1'b0;
      o_ill   <= 1'b0;
    end else if (bus.flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_op    <= d_op;
      o_rd    <= d_rd;
      o_rs    <= d_rs_val;
      o_rt    <= d_rt_val;
      o_imm   <= d_imm;
      o_wr    <= d_wr;
      o_ill   <= d_ill;
    end else if (bus.out_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign bus.out_valid   = o_valid;
  assign bus.out_opcode  = o_op;
  assign bus.out_rd      = o_rd;
  assign bus.out_rs_val  = o_rs;
  assign bus.out_rt_val  = o_rt;
  assign bus.out_imm     = o_imm;
  assign bus.out_wr_en   = o_wr;
  assign bus.out_illegal = o_ill;

endmodule

// File: tb/tb_decode_rf_stage.sv
// Directed bench for decode_rf_stage: decode, bypass, RAW stall, backpressure, flush, reset.
module tb_decode_rf_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned AW     = 5;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  decode_rf_stage_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  decode_rf_stage #(.DATA_W(DATA_W), .NREGS(NREGS), .ZERO_REG(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] op, input int rd, input int rs, input int rt);
    return {op, 9'(rd), 9'(rs), 9'(rt)};
  endfunction

  function automatic logic [31:0] mk_lv(input int rd, input logic [19:0] imm);
    return {5'd1, 7'(rd), imm};
  endfunction

  function automatic logic [31:0] mk_cp(input int rd, input int rs);
    return {5'd6, 7'(rd), 20'(rs)};
  endfunction

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_pending", 64'(dut.pending), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Writeback r3, r4 then ADD r5 = r3, r4
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h0000_00AA;
    tick();
    bus.wb_addr = 5'd4; bus.wb_data = 32'h0000_0055;
    tick();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = mk_r(5'd2, 5, 3, 4);
    #1;
    chk("add_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_instr = mk_cp(6, 5);
    #1;
    chk("add_valid", 64'(bus.out_valid), 64'd1);
    chk("add_opcode", 64'(bus.out_opcode), 64'd2);
    chk("add_rd", 64'(bus.out_rd), 64'd5);
    chk("add_rs", 64'(bus.out_rs_val), 64'h0000_00AA);
    chk("add_rt", 64'(bus.out_rt_val), 64'h0000_0055);
    chk("add_wr_en", 64'(bus.out_wr_en), 64'd1);
    chk("add_pend5", 64'(dut.pending[5]), 64'd1);
    chk("raw_stall0", 64'(bus.in_ready), 64'd0);

    // RAW stall until writeback of r5; bypass feeds the CP
    tick();
    chk("raw_drain", 64'(bus.out_valid), 64'd0);
    chk("raw_stall1", 64'(bus.in_ready), 64'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h0000_1234;
    #1;
    chk("raw_release", 64'(bus.in_ready), 64'd1);
    tick();
    bus.wb_en = 1'b0;
    chk("cp_valid", 64'(bus.out_valid), 64'd1);
    chk("cp_opcode", 64'(bus.out_opcode), 64'd6);
    chk("cp_rd", 64'(bus.out_rd), 64'd6);
    chk("cp_bypass", 64'(bus.out_rs_val), 64'h0000_1234);
    chk("cp_rt", 64'(bus.out_rt_val), 64'd0);
    chk("cp_pend5", 64'(dut.pending[5]), 64'd0);

    // Back-to-back LV, then 3 cycles of backpressure
    bus.in_instr = mk_lv(2, 20'hFFFFF);
    tick();
    chk("lv_valid", 64'(bus.out_valid), 64'd1);
    chk("lv_imm", 64'(bus.out_imm), 64'h000F_FFFF);
    chk("lv_rd", 64'(bus.out_rd), 64'd2);
    chk("lv_rs", 64'(bus.out_rs_val), 64'd0);
    bus.out_ready = 1'b0;
    bus.in_instr  = mk_lv(8, 20'h00042);
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_imm", 64'(bus.out_imm), 64'h000F_FFFF);
      chk("bp_rd", 64'(bus.out_rd), 64'd2);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("stream_valid", 64'(bus.out_valid), 64'd1);
    chk("stream_imm", 64'(bus.out_imm), 64'h0000_0042);
    chk("stream_rd", 64'(bus.out_rd), 64'd8);
    tick();
    chk("stream_drain", 64'(bus.out_valid), 64'd0);

    // r0 ignores writes and never stalls; illegal opcode
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h0000_DEAD;
    tick();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = mk_r(5'd2, 1, 0, 0);
    #1;
    chk("r0_no_stall", 64'(bus.in_ready), 64'd1);
    tick();
    chk("r0_rs", 64'(bus.out_rs_val), 64'd0);
    chk("r0_rt", 64'(bus.out_rt_val), 64'd0);
    chk("r0_valid", 64'(bus.out_valid), 64'd1);
    bus.in_instr = {5'd15, 27'h7FF_FFFF};
    tick();
    bus.in_valid = 1'b0;
    chk("ill_flag", 64'(bus.out_illegal), 64'd1);
    chk("ill_opcode", 64'(bus.out_opcode), 64'd15);
    chk("ill_wr_en", 64'(bus.out_wr_en), 64'd0);
    chk("ill_rs", 64'(bus.out_rs_val), 64'd0);
    chk("ill_rt", 64'(bus.out_rt_val), 64'd0);
    chk("ill_rd", 64'(bus.out_rd), 64'd0);
    chk("ill_imm", 64'(bus.out_imm), 64'd0);
    tick();

    // Flush a held ADD r7; pending[7] must drop
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = mk_r(5'd2, 7, 3, 4);
    tick();
    bus.in_valid = 1'b0;
    chk("hold7_valid", 64'(bus.out_valid), 64'd1);
    chk("hold7_rd", 64'(bus.out_rd), 64'd7);
    chk("hold7_pend", 64'(dut.pending[7]), 64'd1);
    bus.flush = 1'b1;
    #1;
    chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    bus.flush = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_pend7", 64'(dut.pending[7]), 64'd0);
    bus.in_valid = 1'b1; bus.in_instr = mk_cp(9, 7); bus.out_ready = 1'b1;
    #1;
    chk("r7_no_stall", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("r7_valid", 64'(bus.out_valid), 64'd1);
    chk("r7_rd", 64'(bus.out_rd), 64'd9);
    chk("r7_rs", 64'(bus.out_rs_val), 64'd0);
    tick();

    // Reset during a held, stalled pipeline
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = mk_r(5'd2, 5, 3, 4);
    tick();
    bus.in_instr = mk_cp(10, 5);
    #1;
    chk("pre_rst_stall", 64'(bus.in_ready), 64'd0);
    chk("pre_rst_pend5", 64'(dut.pending[5]), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_rd", 64'(bus.out_rd), 64'd0);
    chk("mid_rst_rs", 64'(bus.out_rs_val), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_pending", 64'(dut.pending), 64'd0);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk("post_rst_rd", 64'(bus.out_rd), 64'd10);
    chk("post_rst_r5", 64'(bus.out_rs_val), 64'd0);
    bus.in_instr = mk_r(5'd2, 11, 3, 4);
    tick();
    bus.in_valid = 1'b0;
    chk("post_rst_r3", 64'(bus.out_rs_val), 64'd0);
    chk("post_rst_r4", 64'(bus.out_rt_val), 64'd0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
